// File: rtl/matrix_write_arbiter.sv
// matrix_write_arbiter
//   Round-robin arbiter that serialises NUM_LANES result producers onto the
//   matrix compiler's single element write port. It counts one
//   MAX_SIZE_A x MAX_SIZE_B frame, waits for load_complete, and then holds
//   every lane off until the compiler reports idle again.
//   Optional macro DUP_DETECT_EN: per-address tracker that drops repeated
//   writes within a frame and pulses dup_err.

module matrix_write_arbiter_lane #(
  parameter int PW  = 2,
  parameter int IDX = 0
) (
  input  logic          valid,
  input  logic [PW-1:0] ptr,
  output logic          hi_req
);
  // A lane at or above the pointer beats any lane that wrapped around below it
  assign hi_req = valid && (PW'(IDX) >= ptr);
endmodule

module matrix_write_arbiter #(
  parameter int  NUM_LANES        = 4,
  parameter int  MAX_ELEMENT_SIZE = 8,
  parameter int  MAX_SIZE_A       = 32,
  parameter int  MAX_SIZE_B       = 32,
  parameter int  LC_TIMEOUT       = 64,
  localparam int W  = MAX_ELEMENT_SIZE,
  localparam int AW = $clog2(MAX_SIZE_A),
  localparam int BW = $clog2(MAX_SIZE_B),
  localparam int CW = $clog2(MAX_SIZE_A*MAX_SIZE_B)+1
) (
  input  logic                    inter_refclk,
  input  logic                    rst,
  input  logic [NUM_LANES-1:0]    lane_valid,
  output logic [NUM_LANES-1:0]    lane_ready,
  input  logic [NUM_LANES*AW-1:0] lane_row,
  input  logic [NUM_LANES*BW-1:0] lane_col,
  input  logic [NUM_LANES*W-1:0]  lane_data,
  output logic                    valid_data_in,
  output logic [AW-1:0]           row_addr,
  output logic [BW-1:0]           col_addr,
  output logic [W-1:0]            matrix_element,
  input  logic                    load_complete,
  input  logic                    compiler_idle,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    lc_timeout_err,
`ifdef DUP_DETECT_EN
  output logic                    dup_err,
`endif
  output logic [CW-1:0]           elem_count
);
  localparam int FRAME = MAX_SIZE_A*MAX_SIZE_B;
  localparam int PW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int TW    = $clog2(LC_TIMEOUT+1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_LC, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          fd_q, fd_d, to_q, to_d;
  logic          vld_q, vld_d;
  logic [AW-1:0] row_q, row_d;
  logic [BW-1:0] col_q, col_d;
  logic [W-1:0]  data_q, data_d;

  logic [NUM_LANES-1:0] hi_req;
  logic                 gnt_found;
  logic [PW-1:0]        gnt_idx;
  logic                 accept, fwd;
  logic [AW-1:0]        sel_row;
  logic [BW-1:0]        sel_col;
  logic [W-1:0]         sel_data;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    matrix_write_arbiter_lane #(.PW(PW), .IDX(i)) u_lane (
      .valid  (lane_valid[i]),
      .ptr    (ptr_q),
      .hi_req (hi_req[i])
    );
  end

  // Circular first-set search: lowest lane at/above the pointer, else lowest overall
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_LANES-1; i >= 0; i--)
      if (hi_req[i]) begin gnt_found = 1'b1; gnt_idx = PW'(i); end
    if (!(|hi_req))
      for (int i = NUM_LANES-1; i >= 0; i--)
        if (lane_valid[i]) begin gnt_found = 1'b1; gnt_idx = PW'(i); end
  end

  assign accept = (state_q == S_LOAD) && gnt_found;

  // Grant one-hot and the granted lane's beat
  always_comb begin
    lane_ready = '0;
    sel_row    = '0;
    sel_col    = '0;
    sel_data   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (gnt_idx == PW'(i)) begin
        lane_ready[i] = accept;
        sel_row       = lane_row[i*AW +: AW];
        sel_col       = lane_col[i*BW +: BW];
        sel_data      = lane_data[i*W +: W];
      end
    end
  end

`ifdef DUP_DETECT_EN
  localparam int IW = $clog2(FRAME);
  logic [FRAME-1:0] seen_q, seen_d;
  logic [31:0]      addr_full;
  logic             in_range, is_dup, dup_q, dup_d;

  assign addr_full = 32'(sel_row) * MAX_SIZE_B + 32'(sel_col);
  assign in_range  = addr_full < FRAME;
  assign is_dup    = in_range && seen_q[addr_full[IW-1:0]];
  assign fwd       = accept && !is_dup;
  assign dup_d     = accept && is_dup;
  assign dup_err   = dup_q;

  // Address tracker: mark forwarded writes, wipe while idle between frames
  always_comb begin
    seen_d = seen_q;
    if (state_q == S_IDLE)   seen_d = '0;
    else if (fwd && in_range) seen_d[addr_full[IW-1:0]] = 1'b1;
  end

  // Tracker and dup pulse registers
  always_ff @(posedge inter_refclk) begin
    if (rst) begin
      seen_q <= '0;
      dup_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      dup_q  <= dup_d;
    end
  end
`else
  assign fwd = accept;
`endif

  // Frame sequencer: next state, pointer, beat/timeout counters and pulses
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    fd_d    = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      S_IDLE: if (|lane_valid) state_d = S_LOAD;
      S_LOAD: begin
        if (accept)
          ptr_d = (gnt_idx == PW'(NUM_LANES-1)) ? '0 : gnt_idx + PW'(1);
        if (fwd) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(FRAME-1)) begin
            wait_d = '0;
            // a load_complete coincident with the last beat counts
            if (load_complete) begin state_d = S_HOLD; fd_d = 1'b1; end
            else               state_d = S_WAIT_LC;
          end
        end
      end
      S_WAIT_LC: begin
        if (load_complete) begin
          state_d = S_HOLD;
          fd_d    = 1'b1;
        end else if (wait_q == TW'(LC_TIMEOUT-1)) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          wait_d  = wait_q + TW'(1);
        end
      end
      S_HOLD: if (compiler_idle) begin state_d = S_IDLE; cnt_d = '0; end
      default: state_d = S_IDLE;
    endcase
  end

  // Write port: strobe follows each forwarded accept, address/data hold otherwise
  always_comb begin
    vld_d  = fwd;
    row_d  = fwd ? sel_row  : row_q;
    col_d  = fwd ? sel_col  : col_q;
    data_d = fwd ? sel_data : data_q;
  end

  // State and output registers, synchronous reset
  always_ff @(posedge inter_refclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      fd_q    <= 1'b0;
      to_q    <= 1'b0;
      vld_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      fd_q    <= fd_d;
      to_q    <= to_d;
      vld_q   <= vld_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

  assign valid_data_in  = vld_q;
  assign row_addr       = row_q;
  assign col_addr       = col_q;
  assign matrix_element = data_q;
  assign busy           = (state_q != S_IDLE);
  assign frame_done     = fd_q;
  assign lc_timeout_err = to_q;
  assign elem_count     = cnt_q;
endmodule

// File: tb/tb_matrix_write_arbiter.sv
// Directed bench for matrix_write_arbiter (4 lanes, 2x2 frame, LC_TIMEOUT=8).
// A small frame model predicts grants, counters and pulses; forwarded beats
// go through a scoreboard queue and are checked one cycle later.
`timescale 1ns/1ps
module tb_matrix_write_arbiter;
  localparam int NL = 4, W = 8, A = 2, B = 2, TO = 8;
  localparam int AW = $clog2(A), BW = $clog2(B), FR = A*B, CW = $clog2(FR)+1;
  localparam int S_IDLE = 0, S_LOAD = 1, S_WAIT = 2, S_HOLD = 3;

  typedef struct packed { logic [AW-1:0] r; logic [BW-1:0] c; logic [W-1:0] d; } beat_t;

  logic                 inter_refclk = 1'b0;
  logic                 rst = 1'b1;
  logic [NL-1:0]        lane_valid, lane_ready;
  logic [NL*AW-1:0]     lane_row;
  logic [NL*BW-1:0]     lane_col;
  logic [NL*W-1:0]      lane_data;
  logic                 valid_data_in;
  logic [AW-1:0]        row_addr;
  logic [BW-1:0]        col_addr;
  logic [W-1:0]         matrix_element;
  logic                 load_complete, compiler_idle;
  logic                 busy, frame_done, lc_timeout_err;
  logic [CW-1:0]        elem_count;
`ifdef DUP_DETECT_EN
  logic                 dup_err;
`endif

  logic [AW-1:0] lr[NL];
  logic [BW-1:0] lcol[NL];
  logic [W-1:0]  ld[NL];

  int    checks = 0, errors = 0;
  beat_t sb[$];
  int    dq[$];
  int    mst, mptr, mcnt, mwait, naddr, n;
  bit    seen[FR];
  bit    keep_addr;
  beat_t last;

  always #5 inter_refclk = ~inter_refclk;

  always_comb begin
    lane_row = '0; lane_col = '0; lane_data = '0;
    for (int i = 0; i < NL; i++) begin
      lane_row[i*AW +: AW] = lr[i];
      lane_col[i*BW +: BW] = lcol[i];
      lane_data[i*W +: W]  = ld[i];
    end
  end

  matrix_write_arbiter #(
    .NUM_LANES(NL), .MAX_ELEMENT_SIZE(W), .MAX_SIZE_A(A), .MAX_SIZE_B(B), .LC_TIMEOUT(TO)
  ) dut (
    .inter_refclk(inter_refclk), .rst(rst),
    .lane_valid(lane_valid), .lane_ready(lane_ready),
    .lane_row(lane_row), .lane_col(lane_col), .lane_data(lane_data),
    .valid_data_in(valid_data_in), .row_addr(row_addr), .col_addr(col_addr),
    .matrix_element(matrix_element),
    .load_complete(load_complete), .compiler_idle(compiler_idle),
    .busy(busy), .frame_done(frame_done), .lc_timeout_err(lc_timeout_err),
`ifdef DUP_DETECT_EN
    .dup_err(dup_err),
`endif
    .elem_count(elem_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mst = S_IDLE; mptr = 0; mcnt = 0; mwait = 0;
    sb.delete();
    last = '0;
    foreach (seen[i]) seen[i] = 1'b0;
  endtask

  task automatic refresh(input int i);
    ld[i] = W'($urandom);
    if (!keep_addr) begin
      lr[i]   = AW'(naddr / B);
      lcol[i] = BW'(naddr % B);
      naddr   = (naddr + 1) % FR;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid_data_in), 64'(0));
    chk({tag, "_row"},   64'(row_addr), 64'(0));
    chk({tag, "_col"},   64'(col_addr), 64'(0));
    chk({tag, "_data"},  64'(matrix_element), 64'(0));
    chk({tag, "_busy"},  64'(busy), 64'(0));
    chk({tag, "_fd"},    64'(frame_done), 64'(0));
    chk({tag, "_to"},    64'(lc_timeout_err), 64'(0));
    chk({tag, "_cnt"},   64'(elem_count), 64'(0));
    chk({tag, "_ready"}, 64'(lane_ready), 64'(0));
  endtask

  // One clock: predict grant, push scoreboard, step model, then check outputs
  task automatic cycle();
    int g, ai;
    bit acc, dup, fwd, efd, eto;
    logic [NL-1:0] erdy;
    beat_t b;
    #1;
    g = -1;
    if (mst == S_LOAD)
      for (int k = 0; k < NL; k++)
        if (g < 0 && lane_valid[(mptr+k)%NL]) g = (mptr+k)%NL;
    erdy = '0;
    if (g >= 0) erdy[g] = 1'b1;
    chk("lane_ready", 64'(lane_ready), 64'(erdy));
    for (int i = 0; i < NL; i++) if (lane_ready[i]) dq.push_back(i);
    acc = (g >= 0); dup = 1'b0; fwd = acc; ai = 0;
    if (acc) begin
      ai = int'(lr[g])*B + int'(lcol[g]);
`ifdef DUP_DETECT_EN
      dup = seen[ai];
`endif
      fwd  = !dup;
      mptr = (g + 1) % NL;
      if (fwd) begin
        b.r = lr[g]; b.c = lcol[g]; b.d = ld[g];
        sb.push_back(b);
        seen[ai] = 1'b1;
      end
    end
    efd = 1'b0; eto = 1'b0;
    case (mst)
      S_IDLE: if (|lane_valid) mst = S_LOAD;
      S_LOAD: if (fwd) begin
        mcnt++;
        if (mcnt == FR) begin
          mwait = 0;
          if (load_complete) begin mst = S_HOLD; efd = 1'b1; end
          else mst = S_WAIT;
        end
      end
      S_WAIT: begin
        if (load_complete) begin mst = S_HOLD; efd = 1'b1; end
        else if (mwait == TO-1) begin mst = S_IDLE; eto = 1'b1; mcnt = 0; end
        else mwait++;
      end
      default: if (compiler_idle) begin mst = S_IDLE; mcnt = 0; end
    endcase
    if (mst == S_IDLE) foreach (seen[i]) seen[i] = 1'b0;
    @(posedge inter_refclk); #1;
    if (acc) refresh(g);
    if (sb.size() > 0) begin
      b = sb.pop_front();
      chk("valid_data_in", 64'(valid_data_in), 64'(1));
      chk("row_addr", 64'(row_addr), 64'(b.r));
      chk("col_addr", 64'(col_addr), 64'(b.c));
      chk("matrix_element", 64'(matrix_element), 64'(b.d));
      last = b;
    end else begin
      chk("valid_data_in_idle", 64'(valid_data_in), 64'(0));
      chk("row_hold", 64'(row_addr), 64'(last.r));
      chk("col_hold", 64'(col_addr), 64'(last.c));
      chk("data_hold", 64'(matrix_element), 64'(last.d));
    end
    chk("busy", 64'(busy), 64'(mst != S_IDLE));
    chk("elem_count", 64'(elem_count), 64'(mcnt));
    chk("frame_done", 64'(frame_done), 64'(efd));
    chk("lc_timeout_err", 64'(lc_timeout_err), 64'(eto));
`ifdef DUP_DETECT_EN
    chk("dup_err", 64'(dup_err), 64'(acc && dup));
`endif
  endtask

  // Run until the model leaves IDLE/LOAD; optionally raise load_complete on the last beat
  task automatic run_frame(input bit lc_last);
    int k;
    k = 0;
    while ((mst == S_IDLE || mst == S_LOAD) && k < 40) begin
      load_complete = lc_last && mst == S_LOAD && mcnt == FR-1;
      cycle();
      k++;
    end
    load_complete = 1'b0;
    chk("frame_bound", 64'(k < 40), 64'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    lane_valid = '0; load_complete = 1'b0; compiler_idle = 1'b0;
    keep_addr = 1'b0; naddr = 0;
    for (int i = 0; i < NL; i++) refresh(i);
    model_reset();

    // reset and idle
    repeat (2) @(posedge inter_refclk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    repeat (10) cycle();

    // frame 1: all lanes, load_complete after the frame, then compiler idle
    lane_valid = '1;
    run_frame(1'b0);
    #1;
    chk("ready_after_last", 64'(lane_ready), 64'(0));
    load_complete = 1'b1;
    cycle();
    load_complete = 1'b0;
    chk("frame_done_pulse", 64'(frame_done), 64'(1));
    chk("busy_in_hold", 64'(busy), 64'(1));
    repeat (2) cycle();
    lane_valid = '0;
    compiler_idle = 1'b1;
    cycle();
    compiler_idle = 1'b0;
    chk("busy_after_idle", 64'(busy), 64'(0));
    chk("count_after_idle", 64'(elem_count), 64'(0));

    // frame 2: load_complete coincident with the last beat
    lane_valid = '1;
    run_frame(1'b1);
    chk("fd_same_cycle", 64'(frame_done), 64'(1));
    lane_valid = '0;
    compiler_idle = 1'b1;
    cycle();
    compiler_idle = 1'b0;

    // fairness across two frames
    chk("grant_total", 64'(dq.size()), 64'(8));
    for (int k = 0; k < 8 && k < dq.size(); k++)
      chk($sformatf("grant_%0d", k), 64'(dq[k]), 64'(k % NL));

    // frame 3: lanes 1,3 only, a gap with no valid, then timeout
    lane_valid = 4'b1010;
    cycle(); cycle();
    lane_valid = '0;
    cycle();
    lane_valid = 4'b1010;
    run_frame(1'b0);
    lane_valid = '0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("grant_sparse_%0d", k), 64'((8+k < dq.size()) ? dq[8+k] : -1), 64'((k % 2) ? 3 : 1));
    n = 0;
    do begin cycle(); n++; end while (!lc_timeout_err && n < 20);
    chk("timeout_latency", 64'(n), 64'(TO));
    cycle();
    chk("idle_after_timeout", 64'(busy), 64'(0));

    // reset in the middle of LOAD
    lane_valid = '1;
    repeat (3) cycle();
    rst = 1'b1;
    @(posedge inter_refclk); #1;
    check_zero("midrst");
    rst = 1'b0;
    model_reset();
    cycle();
    #1;
    chk("post_rst_grant", 64'(lane_ready), 64'(1));
    run_frame(1'b1);
    lane_valid = '0;
    compiler_idle = 1'b1;
    cycle();
    compiler_idle = 1'b0;

`ifdef DUP_DETECT_EN
    // duplicate address from lane 1
    rst = 1'b1;
    @(posedge inter_refclk); #1;
    rst = 1'b0;
    model_reset();
    keep_addr = 1'b1;
    lr[1] = AW'(0); lcol[1] = BW'(1);
    lane_valid = 4'b0010;
    repeat (3) cycle();
    chk("dup_pulse", 64'(dup_err), 64'(1));
    chk("dup_no_valid", 64'(valid_data_in), 64'(0));
    chk("dup_count", 64'(elem_count), 64'(1));
    lane_valid = '0;
    cycle();
    keep_addr = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_write_arbiter.md
Name: matrix_write_arbiter

Overview:
- Round-robin arbiter and frame sequencer that shares the matrix compiler's single element write port among NUM_LANES result producers (e.g. systolic-array output rows).
- Serializes lane beats into the compiler's (valid_data_in, row_addr, col_addr, matrix_element) interface and counts one full A×B frame.
- Waits for load_complete, then blocks all lanes until the compiler reports it is idle again after Ethernet transmission.
- Runs entirely in the inter_refclk domain.

Parameters:
- NUM_LANES, 4, number of requesting lanes (2..8).
- MAX_ELEMENT_SIZE, 8, element width W.
- MAX_SIZE_A, 32, rows; AW = $clog2(MAX_SIZE_A).
- MAX_SIZE_B, 32, columns; BW = $clog2(MAX_SIZE_B).
- LC_TIMEOUT, 64, cycles to wait for load_complete before flagging an error.

Ports:
- inter_refclk  in  1  clock
- rst  in  1  reset
- lane_valid  in  NUM_LANES  per-lane beat valid
- lane_ready  out  NUM_LANES  per-lane accept, one-hot or zero
- lane_row  in  NUM_LANES*AW  packed row addresses, lane i at [i*AW+:AW]
- lane_col  in  NUM_LANES*BW  packed column addresses
- lane_data  in  NUM_LANES*W  packed elements
- valid_data_in  out  1  write strobe to compiler
- row_addr  out  AW  write row
- col_addr  out  BW  write column
- matrix_element  out  W  write data
- load_complete  in  1  compiler frame-loaded pulse
- compiler_idle  in  1  compiler back in downtime, level
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when the frame is handed off
- lc_timeout_err  out  1  one-cycle pulse on timeout
- elem_count  out  $clog2(A*B)+1  beats accepted in the current frame

Behaviour:
- Reset is rst: synchronous, active-high. Clock is inter_refclk.
- On reset: all outputs 0, state IDLE, round-robin pointer 0. A reset mid-frame abandons the frame.
- States:
  - IDLE: any lane_valid → LOAD, same cycle.
  - LOAD: grant = first lane with lane_valid set, searching circularly from pointer. lane_ready = grant (combinational), only in LOAD. Accept = lane_valid & lane_ready; at most one beat per cycle. On accept, pointer = granted index + 1 (wrap at NUM_LANES), elem_count++.
  - LOAD → WAIT_LC when accepting beat number A*B. After that, lane_ready = 0.
  - WAIT_LC: counter runs.
    - load_complete → pulse frame_done, go to HOLD.
    - Counter reaches LC_TIMEOUT-1 first → pulse lc_timeout_err, go to IDLE, clear elem_count.
    - load_complete arriving on the same cycle the last beat is accepted is honoured as if it arrived in WAIT_LC.
  - HOLD: lane_ready = 0. When compiler_idle = 1 → IDLE, clear elem_count.
- Output registers: valid_data_in, row_addr, col_addr and matrix_element are registered, one-cycle latency from accept. With no accept, valid_data_in = 0 and address/data hold their last value.
- Row and column are forwarded unmodified. No range checking.
- lane_valid deasserting with no accept is legal; the lane loses nothing.

Optional Feature:
- Macro: DUP_DETECT_EN.
- Defined:
  - A MAX_SIZE_A*MAX_SIZE_B bit tracker marks each accepted address (row*MAX_SIZE_B + col).
  - An accept to an already-marked address is consumed (lane_ready high) but not forwarded: valid_data_in stays 0 and elem_count does not increment.
  - Pulses dup_err (extra 1-bit output, reset 0) on the following cycle.
  - Tracker clears on entering IDLE.
- Not defined: no tracker and no dup_err port. Every accept is forwarded and counted. Upstream must never send duplicate addresses.

Test Plan:
- Reset then idle (A=B=2 build, NUM_LANES=4): all outputs 0, busy 0, lane_ready 0 for 10 cycles.
- Fairness: lanes 0..3 all valid continuously → grants 0,1,2,3,0,…. Each lane gets exactly 1 of every 4 accepts. valid_data_in follows each accept by 1 cycle with the matching row/col/data.
- Frame end: A=B=2, four beats accepted → lane_ready drops to 0 immediately after the 4th. Then load_complete pulse → frame_done pulse next cycle, busy stays 1. compiler_idle=1 → busy 0 and elem_count 0.
- Timeout: LC_TIMEOUT=8, full frame with no load_complete → lc_timeout_err pulse exactly 8 cycles after entering WAIT_LC, then state IDLE.
- Reset mid-LOAD after 2 beats → next cycle all outputs 0. Following frame starts with grant from lane 0.
- DUP_DETECT_EN build: lane 1 sends (0,1) twice → second beat accepted, no valid_data_in, dup_err pulse, elem_count unchanged at 1.
